// File: rtl/regfile_pkg.sv
// Shared register-file constants and index/data types for the write-back path.
// No logic, so no latency.
// No flow control of its own.
package regfile_pkg;

    localparam int REG_W    = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_idx_t REG_ZERO = reg_idx_t'(0);

endpackage

// File: rtl/regfile_wb_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps upward; the pointer moves past the winner.
// Grant is combinational in the request cycle; the pointer updates on the following edge.
// Requesters stall (no grant) until their turn; adv=0 freezes the pointer.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_nxt;
    int            idx;

    // Walk offsets high to low so the smallest offset from ptr is the last (winning) assignment.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                ptr_nxt  = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv && (|gnt)) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ write-back sources and tracks pending writes.
// Grant in cycle N, wr_en in N+1, busy clear visible in N+2; issue in N sets busy in N+1.
// Losers see req_ready=0 and must hold valid/reg/data until granted; one write per cycle.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*REG_W-1:0]    req_reg,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic                     wr_en,
    output logic [REG_W-1:0]         wr_reg,
    output logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_valid,
    input  logic [REG_W-1:0]         issue_reg,
    input  logic [REG_W-1:0]         src1_reg,
    input  logic [REG_W-1:0]         src2_reg,
    output logic                     src1_busy,
    output logic                     src2_busy,
    output logic [NUM_REGS-1:0]      busy
);

    localparam int               PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(REG_ZERO);

    logic [NREQ-1:0]     gnt;
    logic [PW-1:0]       rr_ptr;
    logic                xfer;
    logic [REG_W-1:0]    sel_reg;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] busy_nxt;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .adv   (xfer),
        .gnt   (gnt),
        .ptr   (rr_ptr)
    );

    // Ready is a function of valid and the pointer only; reset masks it so nothing is accepted.
    assign req_ready = gnt & {NREQ{rst_n}};
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_reg  = sel_reg  | req_reg[i*REG_W +: REG_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A write to r0 still consumes its grant but never reaches the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= xfer && (sel_reg != ZERO_IDX);
            if (xfer && (sel_reg != ZERO_IDX)) begin
                wr_reg  <= sel_reg;
                wr_data <= sel_data;
            end
        end
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && (issue_reg != ZERO_IDX)) begin
            set_vec = NUM_REGS'(1) << issue_reg;
        end
        if (wr_en) begin
            clr_vec = NUM_REGS'(1) << wr_reg;
        end
        // Set after clear: a same-cycle issue is a new producer and must stay pending.
        busy_nxt    = (busy & ~clr_vec) | set_vec;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign src1_busy = busy[src1_reg];
    assign src2_busy = busy[src2_reg];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes go into a queue checked by a monitor.
module tb_regfile_wb_arbiter;

    localparam int NREQ   = 2;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*REG_W-1:0]  req_reg;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   wr_en;
    logic [REG_W-1:0]       wr_reg;
    logic [DATA_W-1:0]      wr_data;
    logic                   issue_valid;
    logic [REG_W-1:0]       issue_reg;
    logic [REG_W-1:0]       src1_reg;
    logic [REG_W-1:0]       src2_reg;
    logic                   src1_busy;
    logic                   src2_busy;
    logic [15:0]            busy;

    logic [REG_W-1:0]  rreg [NREQ];
    logic [DATA_W-1:0] rdat [NREQ];

    assign req_reg  = {rreg[1], rreg[0]};
    assign req_data = {rdat[1], rdat[0]};

    typedef struct packed {
        logic [REG_W-1:0]  r;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .NREQ   (NREQ),
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .src1_reg    (src1_reg),
        .src2_reg    (src2_reg),
        .src1_busy   (src1_busy),
        .src2_busy   (src2_busy),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got reg %0d data 0x%0h expected none", wr_reg, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wb_reg", 32'(wr_reg), 32'(e.r));
                chk("wb_data", 32'(wr_data), 32'(e.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int k0;
        int k1;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_reg   = '0;
        src1_reg    = '0;
        src2_reg    = '0;
        k0 = 0;
        k1 = 0;
        rreg[0] = 4'd1;  rdat[0] = 16'hA000;
        rreg[1] = 4'd8;  rdat[1] = 16'hB000;
        req_valid = 2'b11;

        // Reset state, with requests already pending
        tick();
        tick();
        @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_reg", 32'(wr_reg), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0);
        tick();
        rst_n = 1'b1;

        // Fairness: both valid for six grants, alternating 0,1,0,1,0,1
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            w = c % 2;
            chk("fair_ready", 32'(req_ready), 32'(1 << w));
            if (c > 0) chk("fair_wr_en", 32'(wr_en), 1);
            if (w == 0) exp_q.push_back({4'(1 + k0), 16'(16'hA000 + k0)});
            else        exp_q.push_back({4'(8 + k1), 16'(16'hB000 + k1)});
            tick();
            if (w == 0) begin
                k0++;
                rreg[0] = 4'(1 + k0); rdat[0] = 16'(16'hA000 + k0);
            end else begin
                k1++;
                rreg[1] = 4'(8 + k1); rdat[1] = 16'(16'hB000 + k1);
            end
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("fair_last_wr_en", 32'(wr_en), 1);
        tick();
        @(negedge clk);
        chk("fair_idle_wr_en", 32'(wr_en), 0);

        // Single write from requester 1
        tick();
        req_valid = 2'b10; rreg[1] = 4'd5; rdat[1] = 16'hBEEF;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'b10);
        exp_q.push_back({4'd5, 16'hBEEF});
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("single_wr_en", 32'(wr_en), 1);
        tick();
        @(negedge clk);
        chk("single_wr_en_off", 32'(wr_en), 0);

        // Write to r0 and issue to r0 are both discarded
        tick();
        req_valid = 2'b01; rreg[0] = 4'd0; rdat[0] = 16'h1234;
        issue_valid = 1'b1; issue_reg = 4'd0;
        @(negedge clk);
        chk("r0_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00; issue_valid = 1'b0;
        @(negedge clk);
        chk("r0_wr_en", 32'(wr_en), 0);
        chk("r0_busy", 32'(busy), 0);

        // Scoreboard set by issue, cleared two cycles after the grant
        tick();
        issue_valid = 1'b1; issue_reg = 4'd3; src1_reg = 4'd3; src2_reg = 4'd4;
        @(negedge clk);
        chk("sb_src1_before", 32'(src1_busy), 0);
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("sb_src1_set", 32'(src1_busy), 1);
        chk("sb_src2_clear", 32'(src2_busy), 0);
        chk("sb_busy_vec", 32'(busy), 32'h0008);
        tick();
        req_valid = 2'b10; rreg[1] = 4'd3; rdat[1] = 16'h0033;
        @(negedge clk);
        chk("sb_ready", 32'(req_ready), 32'b10);
        exp_q.push_back({4'd3, 16'h0033});
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("sb_wr_en", 32'(wr_en), 1);
        chk("sb_no_bypass", 32'(src1_busy), 1);
        tick();
        @(negedge clk);
        chk("sb_src1_cleared", 32'(src1_busy), 0);
        chk("sb_busy_zero", 32'(busy), 0);

        // Same-cycle set and clear of r7: set wins
        tick();
        issue_valid = 1'b1; issue_reg = 4'd7; src2_reg = 4'd7;
        tick();
        issue_valid = 1'b0;
        req_valid = 2'b01; rreg[0] = 4'd7; rdat[0] = 16'h7777;
        @(negedge clk);
        chk("col_src2_set", 32'(src2_busy), 1);
        chk("col_ready", 32'(req_ready), 32'b01);
        exp_q.push_back({4'd7, 16'h7777});
        tick();
        req_valid = 2'b00;
        issue_valid = 1'b1; issue_reg = 4'd7;
        @(negedge clk);
        chk("col_wr_en", 32'(wr_en), 1);
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("col_busy", 32'(busy), 32'h0080);
        chk("col_src2_busy", 32'(src2_busy), 1);

        // Build busy=0x00F0, put a write in flight, then assert reset mid-cycle
        for (int r = 4; r < 7; r++) begin
            tick();
            issue_valid = 1'b1; issue_reg = 4'(r);
        end
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'h00F0);
        tick();
        req_valid = 2'b01; rreg[0] = 4'd9; rdat[0] = 16'h9999;
        @(negedge clk);
        chk("pre_rst_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b11;
        rreg[0] = 4'hC; rdat[0] = 16'hCCCC;
        rreg[1] = 4'hD; rdat[1] = 16'hDDDD;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_wr_reg", 32'(wr_reg), 0);
        chk("mid_rst_wr_data", 32'(wr_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'b01);
        exp_q.push_back({4'hC, 16'hCCCC});
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("post_rst_wr_en", 32'(wr_en), 1);
        tick();
        tick();
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
